// File: rtl/load_store_unit.sv
// Multicycle RV32I load/store engine: one req/ack data-memory transaction per
// launch, store lane steering, load extract/extend and register-file write-back.
//
// Ports:
//   clk, rst (async, active-low)
//   start, is_store, funct3, addr, store_data, rd  : launch from control FSM
//   mem_req, mem_we, mem_addr, mem_wdata, mem_be   : data-memory request
//   mem_rdata, mem_ack                             : data-memory response
//   rf_we, rf_rd, rf_wdata                         : register-file write port
//   busy, done, fault                              : status to control FSM
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [4:0]            rd,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic                  rf_we,
    output logic [4:0]            rf_rd,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            fault
);

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        WB,
        DONE,
        FAULT
    } state_t;

    state_t state_q, state_n;

    logic                  st_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            be_q;
    logic [4:0]            rd_q;
    logic [7:0]            cnt_q;
    logic [DATA_WIDTH-1:0] ld_q;
    logic [1:0]            fcode_q;

    logic                  ok;
    logic [DATA_WIDTH-1:0] lane_wd;
    logic [3:0]            lane_be;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH-1:0] ext;

    // Launch check: legal width for the direction, natural alignment.
    always_comb begin
        ok = 1'b0;
        unique case (funct3)
            3'b000: ok = 1'b1;
            3'b001: ok = ~addr[0];
            3'b010: ok = (addr[1:0] == 2'b00);
            3'b100: ok = ~is_store;
            3'b101: ok = ~is_store & ~addr[0];
            default: ok = 1'b0;
        endcase
    end

    // Replicate the store datum across lanes; enables pick the real lane.
    always_comb begin
        lane_wd = store_data;
        lane_be = 4'b1111;
        if (is_store) begin
            unique case (funct3)
                3'b000: begin
                    lane_wd = {4{store_data[7:0]}};
                    lane_be = 4'b0001 << addr[1:0];
                end
                3'b001: begin
                    lane_wd = {2{store_data[15:0]}};
                    lane_be = 4'b0011 << addr[1:0];
                end
                default: begin
                    lane_wd = store_data;
                    lane_be = 4'b1111;
                end
            endcase
        end else begin
            lane_wd = '0;
        end
    end

    assign sh = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ext = sh;
        unique case (f3_q)
            3'b000: ext = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
            3'b001: ext = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b100: ext = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
            3'b101: ext = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
            default: ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_n = ok ? ACCESS : FAULT;
            end
            ACCESS: begin
                if (mem_ack)             state_n = st_q ? DONE : WB;
                else if (cnt_q == LIMIT) state_n = FAULT;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            ld_q    <= '0;
            fcode_q <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                st_q    <= is_store;
                f3_q    <= funct3;
                addr_q  <= addr;
                wdata_q <= lane_wd;
                be_q    <= lane_be;
                rd_q    <= rd;
            end
            if (state_q == ACCESS) begin
                if (mem_ack) ld_q  <= ext;
                else         cnt_q <= cnt_q + 8'd1;
            end else begin
                cnt_q <= '0;
            end
            if (state_n == FAULT)
                fcode_q <= (state_q == IDLE) ? 2'b01 : 2'b10;
        end
    end

    // Outputs decode only registered state, so reset clears them at once.
    always_comb begin
        mem_req   = (state_q == ACCESS);
        mem_we    = mem_req & st_q;
        mem_addr  = mem_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        mem_wdata = mem_req ? wdata_q : '0;
        mem_be    = mem_req ? be_q : '0;
        rf_we     = (state_q == WB);
        rf_rd     = rf_we ? rd_q : '0;
        rf_wdata  = rf_we ? ld_q : '0;
        busy      = (state_q != IDLE);
        done      = (state_q == WB) | (state_q == DONE) | (state_q == FAULT);
        fault     = (state_q == FAULT) ? fcode_q : 2'b00;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table of directed load/store vectors plus
// hand-written timeout, limit-ack, ignored-start and mid-access reset sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        busy, done;
    logic [1:0]  fault;

    int n_pass = 0;
    int n_tot  = 0;

    load_store_unit #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .rf_we(rf_we), .rf_rd(rf_rd),
        .rf_wdata(rf_wdata), .busy(busy), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rdat;
        logic [4:0]  r;
        int          dly;
        logic [1:0]  ef;
        logic [31:0] maddr;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [31:0] erf;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        else
            n_pass++;
    endtask

    function automatic vec_t mk(logic st, logic [2:0] f3, logic [31:0] a,
                                logic [31:0] sd, logic [31:0] rdat,
                                logic [4:0] r, int dly, logic [1:0] ef,
                                logic [31:0] maddr, logic [3:0] ebe,
                                logic [31:0] ewd, logic [31:0] erf);
        vec_t v;
        v.st = st; v.f3 = f3; v.a = a; v.sd = sd; v.rdat = rdat;
        v.r = r; v.dly = dly; v.ef = ef; v.maddr = maddr;
        v.ebe = ebe; v.ewd = ewd; v.erf = erf;
        return v;
    endfunction

    task automatic launch(input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [4:0] r);
        @(negedge clk);
        start = 1'b1; is_store = st; funct3 = f3;
        addr = a; store_data = sd; rd = r;
        @(negedge clk);
        start = 1'b0;
        addr = 32'hFFFF_FFFF; store_data = 32'h0; rd = 5'd31;
        funct3 = 3'b111;
    endtask

    task automatic run(input vec_t t, input string nm);
        launch(t.st, t.f3, t.a, t.sd, t.r);
        if (t.ef != 2'b00) begin
            chk({nm, "/done"}, 32'(done), 32'd1);
            chk({nm, "/fault"}, 32'(fault), 32'(t.ef));
            chk({nm, "/req"}, 32'(mem_req), 32'd0);
            chk({nm, "/rfwe"}, 32'(rf_we), 32'd0);
        end else begin
            for (int i = 0; i <= t.dly; i++) begin
                chk({nm, "/req"}, 32'(mem_req), 32'd1);
                chk({nm, "/we"}, 32'(mem_we), 32'(t.st));
                chk({nm, "/maddr"}, mem_addr, t.maddr);
                chk({nm, "/be"}, 32'(mem_be), 32'(t.ebe));
                if (t.st) chk({nm, "/wdata"}, mem_wdata, t.ewd);
                chk({nm, "/rfwe_acc"}, 32'(rf_we), 32'd0);
                chk({nm, "/done_acc"}, 32'(done), 32'd0);
                if (i == t.dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = t.rdat;
                end
                @(negedge clk);
            end
            mem_ack = 1'b0;
            mem_rdata = 32'h0;
            chk({nm, "/done"}, 32'(done), 32'd1);
            chk({nm, "/fault"}, 32'(fault), 32'd0);
            chk({nm, "/req_off"}, 32'(mem_req), 32'd0);
            chk({nm, "/rfwe"}, 32'(rf_we), 32'(!t.st));
            if (!t.st) begin
                chk({nm, "/rfrd"}, 32'(rf_rd), 32'(t.r));
                chk({nm, "/rfwdata"}, rf_wdata, t.erf);
            end
        end
        @(negedge clk);
        chk({nm, "/busy_end"}, 32'(busy), 32'd0);
        chk({nm, "/done_end"}, 32'(done), 32'd0);
        chk({nm, "/rfwe_end"}, 32'(rf_we), 32'd0);
    endtask

    initial begin
        //          st   f3      addr          sdata         rdata         rd  dly ef     maddr         be       wdata         rf
        tbl[0]  = mk(1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0,  2, 2'b00, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        tbl[1]  = mk(1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        0,  0, 2'b00, 32'h0000_0100, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        tbl[2]  = mk(0, 3'b000, 32'h0000_0102, 32'h0,         32'h1280_FF00, 7, 0, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,         32'hFFFF_FF80);
        tbl[3]  = mk(0, 3'b100, 32'h0000_0102, 32'h0,         32'h1280_FF00, 7, 1, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_0080);
        tbl[4]  = mk(0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,        3,  0, 2'b01, 32'h0,         4'b0000, 32'h0,         32'h0);
        tbl[5]  = mk(1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        0,  1, 2'b00, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        tbl[6]  = mk(0, 3'b101, 32'h0000_0202, 32'h0,         32'h8001_1234, 4, 0, 2'b00, 32'h0000_0200, 4'b1111, 32'h0,         32'h0000_8001);
        tbl[7]  = mk(0, 3'b001, 32'h0000_0202, 32'h0,         32'h8001_1234, 5, 2, 2'b00, 32'h0000_0200, 4'b1111, 32'h0,         32'hFFFF_8001);
        tbl[8]  = mk(0, 3'b010, 32'h0000_0204, 32'h0,         32'hCAFE_F00D, 0, 0, 2'b00, 32'h0000_0204, 4'b1111, 32'h0,         32'hCAFE_F00D);
        tbl[9]  = mk(0, 3'b010, 32'h0000_0206, 32'h0,         32'h0,        1,  0, 2'b01, 32'h0,         4'b0000, 32'h0,         32'h0);
        tbl[10] = mk(0, 3'b011, 32'h0000_0200, 32'h0,         32'h0,        1,  0, 2'b01, 32'h0,         4'b0000, 32'h0,         32'h0);
        tbl[11] = mk(0, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_7F00, 9, 0, 2'b00, 32'h0000_0100, 4'b1111, 32'h0,         32'h0000_007F);
        tbl[12] = mk(1, 3'b000, 32'h0000_0101, 32'h1234_5678, 32'h0,        0,  0, 2'b00, 32'h0000_0100, 4'b0010, 32'h7878_7878, 32'h0);

        #12;
        chk("rst/busy", 32'(busy), 32'd0);
        chk("rst/req", 32'(mem_req), 32'd0);
        chk("rst/done", 32'(done), 32'd0);
        chk("rst/rfwe", 32'(rf_we), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++)
            run(tbl[i], $sformatf("vec%0d", i));

        // Timeout: no ack for the whole wait window.
        launch(1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("tmo/req%0d", i), 32'(mem_req), 32'd1);
            chk($sformatf("tmo/done%0d", i), 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("tmo/done", 32'(done), 32'd1);
        chk("tmo/fault", 32'(fault), 32'd2);
        chk("tmo/req_off", 32'(mem_req), 32'd0);
        chk("tmo/rfwe", 32'(rf_we), 32'd0);
        @(negedge clk);
        chk("tmo/busy", 32'(busy), 32'd0);

        // Ack in the last cycle of the window still succeeds.
        run(mk(0, 3'b010, 32'h0000_0310, 32'h0, 32'h1357_9BDF, 5'd6, 4,
               2'b00, 32'h0000_0310, 4'b1111, 32'h0, 32'h1357_9BDF),
            "limit_ack");

        // start while busy is ignored.
        launch(1'b1, 3'b010, 32'h0000_0500, 32'h1111_2222, 5'd0);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0600;
        @(negedge clk);
        start = 1'b0;
        chk("ign/maddr", mem_addr, 32'h0000_0500);
        chk("ign/we", 32'(mem_we), 32'd1);
        chk("ign/wdata", mem_wdata, 32'h1111_2222);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("ign/done", 32'(done), 32'd1);
        chk("ign/rfwe", 32'(rf_we), 32'd0);
        @(negedge clk);
        chk("ign/busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("ign/req", 32'(mem_req), 32'd0);

        // Reset in the middle of ACCESS.
        launch(1'b0, 3'b010, 32'h0000_0400, 32'h0, 5'd9);
        chk("rstm/req_before", 32'(mem_req), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstm/req", 32'(mem_req), 32'd0);
        chk("rstm/busy", 32'(busy), 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rstm/done", 32'(done), 32'd0);
        chk("rstm/rfwe", 32'(rf_we), 32'd0);
        rst = 1'b1;
        run(tbl[3], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
